reg_file_reader: RTL



---
 rtl/reg_file_reader.sv | 94 +++++++++
 1 files changed

// File: rtl/reg_file_reader.sv
// Register storage for operand fetch: one write port, two registered read
// ports with write-through bypass, and a debug engine that dumps every
// register over a valid/ready handshake.
module reg_file_reader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             regWr,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] dataIn,
  input  logic [AW-1:0]    rdAddrA,
  input  logic [AW-1:0]    rdAddrB,
  output logic [WIDTH-1:0] dataOutA,
  output logic [WIDTH-1:0] dataOutB,
  input  logic             dumpStart,
  output logic             dumpBusy,
  output logic             dumpValid,
  input  logic             dumpReady,
  output logic [AW-1:0]    dumpAddr,
  output logic [WIDTH-1:0] dumpData
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [AW-1:0]    index;
  logic             lastEntry;
  logic [WIDTH-1:0] rdA;
  logic [WIDTH-1:0] rdB;
  logic [WIDTH-1:0] rdD;

  assign lastEntry = (index == AW'(DEPTH - 1));
  assign dumpBusy  = (state != IDLE);
  // Valid only while presenting, so an entry is never accepted twice.
  assign dumpValid = (state == SEND);

  // Read values with register 0 forced to zero and same-cycle write bypass.
  always_comb begin
    rdA = regs[rdAddrA];
    rdB = regs[rdAddrB];
    rdD = regs[index];
    if (regWr && wrAddr == rdAddrA) rdA = dataIn;
    if (regWr && wrAddr == rdAddrB) rdB = dataIn;
    if (regWr && wrAddr == index)   rdD = dataIn;
    if (rdAddrA == '0) rdA = '0;
    if (rdAddrB == '0) rdB = '0;
    if (index == '0)   rdD = '0;
  end

  // Dump FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Dump FSM next-state logic; a start request while busy is dropped.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (dumpStart) stateNext = LOAD;
      LOAD:    stateNext = SEND;
      SEND:    if (dumpReady) stateNext = lastEntry ? IDLE : LOAD;
      default: stateNext = IDLE;
    endcase
  end

  // Register array, read-port registers and dump datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs     <= '{default: '0};
      dataOutA <= '0;
      dataOutB <= '0;
      dumpData <= '0;
      dumpAddr <= '0;
      index    <= '0;
    end else begin
      if (regWr && wrAddr != '0) regs[wrAddr] <= dataIn;
      dataOutA <= rdA;
      dataOutB <= rdB;
      if (state == IDLE && dumpStart) index <= '0;
      if (state == LOAD) begin
        dumpData <= rdD;
        dumpAddr <= index;
      end
      if (state == SEND && dumpReady && !lastEntry) index <= index + 1'b1;
    end
  end

endmodule
